lsp: RTL and testbench

Load/store pipe: the responder end of the issue stage's `ix_lsp_*` handshake. It accepts one memory instruction at a time and generates the effective address (AG). It issues a single outstanding request to the data-memory port, holds it in MEM until the response, and presents a registered, extended result in WB. It also drives the MEM/WB hazard and bypass signals consumed by issue.

---
 rtl/lsp_if.sv | 64 ++++++
 rtl/lsp.sv | 216 +++++++++++++++++++++
 tb/tb_lsp.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsp_if.sv
// lsp_if: bundles every signal of the load/store pipe except clock and reset.
//   ix_lsp_*     : issue -> lsp instruction handshake (valid/ready)
//   lsp_ix_mem_* : MEM-stage hazard/bypass info back to issue
//   lsp_wb_*     : registered writeback result
//   lsp_dm_*     : data-memory request/response port
// Modports:
//   slave  : the lsp side (consumes instructions, drives memory requests)
//   master : the environment side (issue stage, data memory, writeback)
interface lsp_if;
  logic [63:0] ix_lsp_pc;
  logic [4:0]  ix_lsp_dst;
  logic        ix_lsp_wb_en;
  logic [63:0] ix_lsp_base;
  logic [11:0] ix_lsp_offset;
  logic [63:0] ix_lsp_source;
  logic        ix_lsp_mem_sign;
  logic [1:0]  ix_lsp_mem_width;
  logic        ix_lsp_valid;
  logic        ix_lsp_ready;

  logic        lsp_ix_mem_busy;
  logic        lsp_ix_mem_wb_en;
  logic [4:0]  lsp_ix_mem_dst;

  logic [4:0]  lsp_wb_dst;
  logic [63:0] lsp_wb_result;
  logic        lsp_wb_wb_en;
  logic [63:0] lsp_wb_pc;
  logic        lsp_wb_misalign;
  logic        lsp_wb_valid;

  logic [63:0] lsp_dm_req_addr;
  logic        lsp_dm_req_wen;
  logic [63:0] lsp_dm_req_wdata;
  logic [7:0]  lsp_dm_req_wmask;
  logic        lsp_dm_req_valid;
  logic        lsp_dm_req_ready;
  logic [63:0] lsp_dm_resp_rdata;
  logic        lsp_dm_resp_valid;

  modport slave (
    input  ix_lsp_pc, ix_lsp_dst, ix_lsp_wb_en, ix_lsp_base, ix_lsp_offset,
           ix_lsp_source, ix_lsp_mem_sign, ix_lsp_mem_width, ix_lsp_valid,
    output ix_lsp_ready,
    output lsp_ix_mem_busy, lsp_ix_mem_wb_en, lsp_ix_mem_dst,
    output lsp_wb_dst, lsp_wb_result, lsp_wb_wb_en, lsp_wb_pc,
           lsp_wb_misalign, lsp_wb_valid,
    output lsp_dm_req_addr, lsp_dm_req_wen, lsp_dm_req_wdata,
           lsp_dm_req_wmask, lsp_dm_req_valid,
    input  lsp_dm_req_ready, lsp_dm_resp_rdata, lsp_dm_resp_valid
  );

  modport master (
    output ix_lsp_pc, ix_lsp_dst, ix_lsp_wb_en, ix_lsp_base, ix_lsp_offset,
           ix_lsp_source, ix_lsp_mem_sign, ix_lsp_mem_width, ix_lsp_valid,
    input  ix_lsp_ready,
    input  lsp_ix_mem_busy, lsp_ix_mem_wb_en, lsp_ix_mem_dst,
    input  lsp_wb_dst, lsp_wb_result, lsp_wb_wb_en, lsp_wb_pc,
           lsp_wb_misalign, lsp_wb_valid,
    input  lsp_dm_req_addr, lsp_dm_req_wen, lsp_dm_req_wdata,
           lsp_dm_req_wmask, lsp_dm_req_valid,
    output lsp_dm_req_ready, lsp_dm_resp_rdata, lsp_dm_resp_valid
  );
endinterface

// File: rtl/lsp.sv
// lsp: load/store pipe. Accepts one memory instruction at a time from issue,
// computes the effective address combinationally (AG), keeps a single
// outstanding data-memory request in MEM, and registers the lane-shifted,
// width-extended load result into WB.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : lsp_if.slave, issue handshake, MEM hazard info, WB outputs and
//           the data-memory request/response port
// Configuration:
//   LSP_MISALIGN_CHECK_EN : when defined, misaligned accesses raise a
//   misalign fault in WB instead of going to memory. When undefined, the low
//   address bits are force-aligned to the access size and lsp_wb_misalign
//   is tied to 0.
module lsp (
  input logic   clk,
  input logic   rst_n,
  lsp_if.slave  bus
);

  typedef enum logic {
    MEM_IDLE,
    MEM_BUSY
  } mem_state_e;

  mem_state_e state_q, state_d;

  logic [63:0] ea;
  logic [2:0]  lane;
  logic [7:0]  size_mask;
  logic        mem_busy;
  logic        mem_free;
  logic        handshake;
  logic        resp_take;

  logic [4:0]  mem_dst;
  logic        mem_wb_en;
  logic [1:0]  mem_width;
  logic        mem_sign;
  logic [2:0]  mem_lane;
  logic [63:0] mem_pc;

  logic [63:0] rdata_shifted;
  logic [63:0] load_result;

`ifdef LSP_MISALIGN_CHECK_EN
  logic [2:0]  align_mask;
  logic        misalign;
  logic        fault_take;
  logic        wb_misalign;
`endif

  // Effective address and the byte-enable pattern of the access size.
  always_comb begin
    ea = bus.ix_lsp_base + {{52{bus.ix_lsp_offset[11]}}, bus.ix_lsp_offset};
    size_mask = 8'h01;
    case (bus.ix_lsp_mem_width)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

`ifdef LSP_MISALIGN_CHECK_EN
  // Lane is taken as-is; a nonzero offset inside the access size is a fault.
  always_comb begin
    lane = ea[2:0];
    align_mask = 3'd0;
    case (bus.ix_lsp_mem_width)
      2'd0:    align_mask = 3'd0;
      2'd1:    align_mask = 3'd1;
      2'd2:    align_mask = 3'd3;
      default: align_mask = 3'd7;
    endcase
    misalign = |(ea[2:0] & align_mask);
  end
`else
  // Without the check, low bits inside the access size are simply dropped.
  always_comb begin
    lane = ea[2:0];
    case (bus.ix_lsp_mem_width)
      2'd0:    lane = ea[2:0];
      2'd1:    lane = {ea[2:1], 1'b0};
      2'd2:    lane = {ea[2], 2'b00};
      default: lane = 3'b000;
    endcase
  end
`endif

  assign mem_busy  = (state_q == MEM_BUSY);
  assign resp_take = mem_busy && bus.lsp_dm_resp_valid;
  // MEM can take a new request in the same cycle its response drains.
  assign mem_free  = !mem_busy || bus.lsp_dm_resp_valid;

  // Request path and issue handshake.
  always_comb begin
    bus.lsp_dm_req_addr  = {ea[63:3], 3'b000};
    bus.lsp_dm_req_wen   = !bus.ix_lsp_wb_en;
    bus.lsp_dm_req_wdata = bus.ix_lsp_source << {lane, 3'b000};
    bus.lsp_dm_req_wmask = bus.ix_lsp_wb_en ? 8'h00 : (size_mask << lane);
`ifdef LSP_MISALIGN_CHECK_EN
    bus.lsp_dm_req_valid = bus.ix_lsp_valid && mem_free && !misalign;
    // A fault waits for MEM to be fully idle so its WB slot can never
    // collide with a response draining from MEM in the same cycle.
    fault_take = bus.ix_lsp_valid && misalign && !mem_busy;
    if (!bus.ix_lsp_valid)
      bus.ix_lsp_ready = 1'b1;
    else if (misalign)
      bus.ix_lsp_ready = !mem_busy;
    else
      bus.ix_lsp_ready = mem_free && bus.lsp_dm_req_ready;
`else
    bus.lsp_dm_req_valid = bus.ix_lsp_valid && mem_free;
    bus.ix_lsp_ready = !bus.ix_lsp_valid || (mem_free && bus.lsp_dm_req_ready);
`endif
    handshake = bus.lsp_dm_req_valid && bus.lsp_dm_req_ready;
  end

  // MEM occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= MEM_IDLE;
    else
      state_q <= state_d;
  end

  // MEM stays busy when a new request refills it as the old one drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (handshake) state_d = MEM_BUSY;
      MEM_BUSY: if (bus.lsp_dm_resp_valid) state_d = handshake ? MEM_BUSY : MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // MEM contents captured on each request handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dst   <= '0;
      mem_wb_en <= 1'b0;
      mem_width <= '0;
      mem_sign  <= 1'b0;
      mem_lane  <= '0;
      mem_pc    <= '0;
    end else if (handshake) begin
      mem_dst   <= bus.ix_lsp_dst;
      mem_wb_en <= bus.ix_lsp_wb_en;
      mem_width <= bus.ix_lsp_mem_width;
      mem_sign  <= bus.ix_lsp_mem_sign;
      mem_lane  <= lane;
      mem_pc    <= bus.ix_lsp_pc;
    end
  end

  assign bus.lsp_ix_mem_busy  = mem_busy;
  assign bus.lsp_ix_mem_wb_en = mem_busy && mem_wb_en;
  assign bus.lsp_ix_mem_dst   = mem_dst;

  // Shift the addressed bytes down to lane 0, then truncate and extend.
  always_comb begin
    rdata_shifted = bus.lsp_dm_resp_rdata >> {mem_lane, 3'b000};
    load_result = rdata_shifted;
    case (mem_width)
      2'd0: load_result = mem_sign ? {{56{rdata_shifted[7]}}, rdata_shifted[7:0]}
                                   : {56'b0, rdata_shifted[7:0]};
      2'd1: load_result = mem_sign ? {{48{rdata_shifted[15]}}, rdata_shifted[15:0]}
                                   : {48'b0, rdata_shifted[15:0]};
      2'd2: load_result = mem_sign ? {{32{rdata_shifted[31]}}, rdata_shifted[31:0]}
                                   : {32'b0, rdata_shifted[31:0]};
      default: load_result = rdata_shifted;
    endcase
    if (!mem_wb_en)
      load_result = '0;
  end

  // WB register: one valid pulse per completed (or faulted) instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.lsp_wb_valid  <= 1'b0;
      bus.lsp_wb_dst    <= '0;
      bus.lsp_wb_pc     <= '0;
      bus.lsp_wb_wb_en  <= 1'b0;
      bus.lsp_wb_result <= '0;
`ifdef LSP_MISALIGN_CHECK_EN
      wb_misalign       <= 1'b0;
`endif
    end else if (resp_take) begin
      bus.lsp_wb_valid  <= 1'b1;
      bus.lsp_wb_dst    <= mem_dst;
      bus.lsp_wb_pc     <= mem_pc;
      bus.lsp_wb_wb_en  <= mem_wb_en;
      bus.lsp_wb_result <= load_result;
`ifdef LSP_MISALIGN_CHECK_EN
      wb_misalign       <= 1'b0;
    end else if (fault_take) begin
      bus.lsp_wb_valid  <= 1'b1;
      bus.lsp_wb_dst    <= bus.ix_lsp_dst;
      bus.lsp_wb_pc     <= bus.ix_lsp_pc;
      bus.lsp_wb_wb_en  <= 1'b0;
      bus.lsp_wb_result <= '0;
      wb_misalign       <= 1'b1;
`endif
    end else begin
      bus.lsp_wb_valid  <= 1'b0;
    end
  end

`ifdef LSP_MISALIGN_CHECK_EN
  assign bus.lsp_wb_misalign = wb_misalign;
`else
  assign bus.lsp_wb_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsp.sv
// tb_lsp: directed self-checking bench for the lsp load/store pipe.
// Drives the issue handshake and plays the data memory by hand, one cycle
// at a time, comparing outputs against hand-computed expected values.
module tb_lsp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lsp_if bus();

  lsp u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checkCount = 0;
  int errorCount = 0;

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction on the issue handshake.
  task automatic applyStimulus(input logic [63:0] pc, input logic [4:0] dst,
                               input logic wbEn, input logic [63:0] base,
                               input logic [11:0] offset, input logic [63:0] source,
                               input logic sign, input logic [1:0] width);
    bus.ix_lsp_pc        = pc;
    bus.ix_lsp_dst       = dst;
    bus.ix_lsp_wb_en     = wbEn;
    bus.ix_lsp_base      = base;
    bus.ix_lsp_offset    = offset;
    bus.ix_lsp_source    = source;
    bus.ix_lsp_mem_sign  = sign;
    bus.ix_lsp_mem_width = width;
    bus.ix_lsp_valid     = 1'b1;
  endtask

  // One access against a memory that answers the cycle after the request.
  task automatic singleAccess(input string tag, input logic [63:0] pc,
                              input logic [4:0] dst, input logic wbEn,
                              input logic [63:0] base, input logic [11:0] offset,
                              input logic [63:0] source, input logic sign,
                              input logic [1:0] width, input logic [63:0] rdata,
                              input logic [63:0] expAddr, input logic [7:0] expMask,
                              input logic [63:0] expWdata, input logic [63:0] expResult);
    applyStimulus(pc, dst, wbEn, base, offset, source, sign, width);
    bus.lsp_dm_req_ready = 1'b1;
    #1;
    checkOutput({tag, "/req_valid"}, 64'(bus.lsp_dm_req_valid), 64'd1);
    checkOutput({tag, "/ix_ready"},  64'(bus.ix_lsp_ready), 64'd1);
    checkOutput({tag, "/req_addr"},  bus.lsp_dm_req_addr, expAddr);
    checkOutput({tag, "/wmask"},     64'(bus.lsp_dm_req_wmask), 64'(expMask));
    checkOutput({tag, "/wen"},       64'(bus.lsp_dm_req_wen), 64'(!wbEn));
    checkOutput({tag, "/wdata"},     bus.lsp_dm_req_wdata, expWdata);
    stepCycle();
    bus.ix_lsp_valid      = 1'b0;
    bus.lsp_dm_resp_valid = 1'b1;
    bus.lsp_dm_resp_rdata = rdata;
    #1;
    checkOutput({tag, "/mem_busy"},  64'(bus.lsp_ix_mem_busy), 64'd1);
    checkOutput({tag, "/mem_dst"},   64'(bus.lsp_ix_mem_dst), 64'(dst));
    checkOutput({tag, "/mem_wb_en"}, 64'(bus.lsp_ix_mem_wb_en), 64'(wbEn));
    stepCycle();
    bus.lsp_dm_resp_valid = 1'b0;
    #1;
    checkOutput({tag, "/wb_valid"},  64'(bus.lsp_wb_valid), 64'd1);
    checkOutput({tag, "/wb_result"}, bus.lsp_wb_result, expResult);
    checkOutput({tag, "/wb_wb_en"},  64'(bus.lsp_wb_wb_en), 64'(wbEn));
    checkOutput({tag, "/wb_dst"},    64'(bus.lsp_wb_dst), 64'(dst));
    checkOutput({tag, "/wb_pc"},     bus.lsp_wb_pc, pc);
    checkOutput({tag, "/mem_idle"},  64'(bus.lsp_ix_mem_busy), 64'd0);
    stepCycle();
    checkOutput({tag, "/wb_pulse"},  64'(bus.lsp_wb_valid), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.ix_lsp_pc         = '0;
    bus.ix_lsp_dst        = '0;
    bus.ix_lsp_wb_en      = 1'b0;
    bus.ix_lsp_base       = '0;
    bus.ix_lsp_offset     = '0;
    bus.ix_lsp_source     = '0;
    bus.ix_lsp_mem_sign   = 1'b0;
    bus.ix_lsp_mem_width  = '0;
    bus.ix_lsp_valid      = 1'b0;
    bus.lsp_dm_req_ready  = 1'b0;
    bus.lsp_dm_resp_rdata = '0;
    bus.lsp_dm_resp_valid = 1'b0;

    // Reset values
    #12;
    checkOutput("rst/wb_valid",    64'(bus.lsp_wb_valid), 64'd0);
    checkOutput("rst/wb_misalign", 64'(bus.lsp_wb_misalign), 64'd0);
    checkOutput("rst/wb_result",   bus.lsp_wb_result, 64'd0);
    checkOutput("rst/wb_pc",       bus.lsp_wb_pc, 64'd0);
    checkOutput("rst/mem_busy",    64'(bus.lsp_ix_mem_busy), 64'd0);
    checkOutput("rst/mem_wb_en",   64'(bus.lsp_ix_mem_wb_en), 64'd0);
    checkOutput("rst/mem_dst",     64'(bus.lsp_ix_mem_dst), 64'd0);
    checkOutput("rst/req_valid",   64'(bus.lsp_dm_req_valid), 64'd0);
    rst_n = 1'b1;
    stepCycle();

    // Doubleword load with negative offset
    singleAccess("ld_d", 64'h100, 5'd5, 1'b1, 64'h1000, 12'hFF8, 64'd0, 1'b0, 2'd3,
                 64'h1122334455667788, 64'hFF8, 8'h00, 64'd0, 64'h1122334455667788);

    // Byte load from lane 3, signed then unsigned
    singleAccess("lb_s", 64'h104, 5'd6, 1'b1, 64'h1000, 12'h003, 64'd0, 1'b1, 2'd0,
                 64'h0000000080000000, 64'h1000, 8'h00, 64'd0, 64'hFFFFFFFFFFFFFF80);
    singleAccess("lb_u", 64'h108, 5'd7, 1'b1, 64'h1000, 12'h003, 64'd0, 1'b0, 2'd0,
                 64'h0000000080000000, 64'h1000, 8'h00, 64'd0, 64'h80);

    // Halfword store into lanes 6-7
    singleAccess("sh", 64'h10C, 5'd8, 1'b0, 64'h2000, 12'h006, 64'hABCD, 1'b0, 2'd1,
                 64'hDEADBEEF, 64'h2000, 8'hC0, 64'hABCD000000000000, 64'd0);

    // Backpressure: request stalled 3 cycles, then a slow response while a
    // second load waits behind it and refills MEM as the first drains.
    applyStimulus(64'h200, 5'd9, 1'b1, 64'h3000, 12'h000, 64'd0, 1'b0, 2'd3);
    bus.lsp_dm_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp/stall_ready%0d", i), 64'(bus.ix_lsp_ready), 64'd0);
      checkOutput($sformatf("bp/stall_req%0d", i),   64'(bus.lsp_dm_req_valid), 64'd1);
      stepCycle();
    end
    bus.lsp_dm_req_ready = 1'b1;
    #1;
    checkOutput("bp/accept_ready", 64'(bus.ix_lsp_ready), 64'd1);
    stepCycle();
    applyStimulus(64'h204, 5'd10, 1'b1, 64'h3008, 12'h000, 64'd0, 1'b0, 2'd3);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("bp/busy%0d", i),    64'(bus.lsp_ix_mem_busy), 64'd1);
      checkOutput($sformatf("bp/wb_en%0d", i),   64'(bus.lsp_ix_mem_wb_en), 64'd1);
      checkOutput($sformatf("bp/dst%0d", i),     64'(bus.lsp_ix_mem_dst), 64'd9);
      checkOutput($sformatf("bp/blocked%0d", i), 64'(bus.ix_lsp_ready), 64'd0);
      checkOutput($sformatf("bp/no_req%0d", i),  64'(bus.lsp_dm_req_valid), 64'd0);
      stepCycle();
    end
    bus.lsp_dm_resp_valid = 1'b1;
    bus.lsp_dm_resp_rdata = 64'hA;
    #1;
    checkOutput("bp/refill_req",   64'(bus.lsp_dm_req_valid), 64'd1);
    checkOutput("bp/refill_ready", 64'(bus.ix_lsp_ready), 64'd1);
    stepCycle();
    bus.ix_lsp_valid      = 1'b0;
    bus.lsp_dm_resp_rdata = 64'hB;
    #1;
    checkOutput("bp/wb1_valid",  64'(bus.lsp_wb_valid), 64'd1);
    checkOutput("bp/wb1_dst",    64'(bus.lsp_wb_dst), 64'd9);
    checkOutput("bp/wb1_result", bus.lsp_wb_result, 64'hA);
    checkOutput("bp/refilled",   64'(bus.lsp_ix_mem_busy), 64'd1);
    checkOutput("bp/refill_dst", 64'(bus.lsp_ix_mem_dst), 64'd10);
    stepCycle();
    bus.lsp_dm_resp_valid = 1'b0;
    #1;
    checkOutput("bp/wb2_valid",  64'(bus.lsp_wb_valid), 64'd1);
    checkOutput("bp/wb2_dst",    64'(bus.lsp_wb_dst), 64'd10);
    checkOutput("bp/wb2_result", bus.lsp_wb_result, 64'hB);
    checkOutput("bp/drained",    64'(bus.lsp_ix_mem_busy), 64'd0);
    stepCycle();

    // Back-to-back: four loads, memory answers the cycle after each request
    for (int k = 0; k < 6; k++) begin
      if (k < 4)
        applyStimulus(64'h500 + 64'(4 * k), 5'(k + 1), 1'b1, 64'h4000 + 64'(8 * k),
                      12'h000, 64'd0, 1'b0, 2'd3);
      else
        bus.ix_lsp_valid = 1'b0;
      bus.lsp_dm_resp_valid = (k >= 1 && k <= 4);
      bus.lsp_dm_resp_rdata = 64'h100 + 64'(k - 1);
      #1;
      if (k < 4) begin
        checkOutput($sformatf("b2b/req%0d", k),   64'(bus.lsp_dm_req_valid), 64'd1);
        checkOutput($sformatf("b2b/ready%0d", k), 64'(bus.ix_lsp_ready), 64'd1);
        checkOutput($sformatf("b2b/addr%0d", k),  bus.lsp_dm_req_addr, 64'h4000 + 64'(8 * k));
      end
      checkOutput($sformatf("b2b/wb_valid%0d", k), 64'(bus.lsp_wb_valid), 64'(k >= 2));
      if (k >= 2) begin
        checkOutput($sformatf("b2b/wb_dst%0d", k),    64'(bus.lsp_wb_dst), 64'(k - 1));
        checkOutput($sformatf("b2b/wb_result%0d", k), bus.lsp_wb_result, 64'h100 + 64'(k - 2));
      end
      stepCycle();
    end
    bus.lsp_dm_resp_valid = 1'b0;
    #1;
    checkOutput("b2b/wb_done", 64'(bus.lsp_wb_valid), 64'd0);
    checkOutput("b2b/idle",    64'(bus.lsp_ix_mem_busy), 64'd0);
    stepCycle();

    // Misaligned word load at 0x1002
`ifdef LSP_MISALIGN_CHECK_EN
    applyStimulus(64'h600, 5'd11, 1'b1, 64'h1000, 12'h002, 64'd0, 1'b0, 2'd2);
    bus.lsp_dm_req_ready = 1'b1;
    #1;
    checkOutput("mis/no_req", 64'(bus.lsp_dm_req_valid), 64'd0);
    checkOutput("mis/ready",  64'(bus.ix_lsp_ready), 64'd1);
    stepCycle();
    bus.ix_lsp_valid = 1'b0;
    #1;
    checkOutput("mis/wb_valid",    64'(bus.lsp_wb_valid), 64'd1);
    checkOutput("mis/wb_misalign", 64'(bus.lsp_wb_misalign), 64'd1);
    checkOutput("mis/wb_wb_en",    64'(bus.lsp_wb_wb_en), 64'd0);
    checkOutput("mis/wb_result",   bus.lsp_wb_result, 64'd0);
    checkOutput("mis/wb_dst",      64'(bus.lsp_wb_dst), 64'd11);
    stepCycle();
`else
    singleAccess("mis", 64'h600, 5'd11, 1'b1, 64'h1000, 12'h002, 64'd0, 1'b0, 2'd2,
                 64'h1122334455667788, 64'h1000, 8'h00, 64'd0, 64'h55667788);
    checkOutput("mis/wb_misalign", 64'(bus.lsp_wb_misalign), 64'd0);
`endif

    // Reset while MEM holds a load; the late response must be ignored
    applyStimulus(64'h700, 5'd12, 1'b1, 64'h5000, 12'h000, 64'd0, 1'b0, 2'd3);
    bus.lsp_dm_req_ready = 1'b1;
    stepCycle();
    bus.ix_lsp_valid = 1'b0;
    #1;
    checkOutput("rstmid/busy_before", 64'(bus.lsp_ix_mem_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid/busy_cleared", 64'(bus.lsp_ix_mem_busy), 64'd0);
    checkOutput("rstmid/dst_cleared",  64'(bus.lsp_ix_mem_dst), 64'd0);
    rst_n = 1'b1;
    bus.lsp_dm_resp_valid = 1'b1;
    bus.lsp_dm_resp_rdata = 64'h5555;
    stepCycle();
    bus.lsp_dm_resp_valid = 1'b0;
    #1;
    checkOutput("rstmid/no_wb",   64'(bus.lsp_wb_valid), 64'd0);
    checkOutput("rstmid/no_busy", 64'(bus.lsp_ix_mem_busy), 64'd0);
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
